// File: rtl/debug_ram_pkg.sv
// Shared definitions for port-A writers of the 1024x8 VGA debug RAM.
package debug_ram_pkg;

  localparam int unsigned DBG_RAM_ADDR_W = 10;
  localparam int unsigned DBG_RAM_DEPTH  = 1024;
  localparam int unsigned DBG_RAM_COLS   = 16;
  localparam int unsigned DBG_RAM_DATA_W = 8;

  // Port-A writer control states
  typedef enum logic [1:0] {
    DBG_WR_CLEAR = 2'd0,
    DBG_WR_RUN   = 2'd1,
    DBG_WR_FULL  = 2'd2
  } dbg_wr_state_e;

endpackage : debug_ram_pkg

// File: rtl/debug_ram_wr.sv
// Sequential byte-stream writer for debug RAM port A with clear sweep.
// Build option: define DEBUG_RAM_WR_WRAP_EN for a circular log that keeps
// writing after full; otherwise the writer stops when the RAM is full.
module debug_ram_wr
  import debug_ram_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DBG_RAM_ADDR_W,
  parameter int unsigned       DATA_W    = DBG_RAM_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear_req,
  output logic              ram_en_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              clearing,
  output logic              full,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_count
);

  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);

  dbg_wr_state_e     state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0]  wr_count_nxt;
  logic              full_nxt, overflow_nxt, clearing_nxt;
  logic              ram_en_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_data_nxt;
  logic              sweep_last_on_port;

  // The last sweep write is on the port: leave CLEAR only after it is issued
  assign sweep_last_on_port = ram_en_a && (ram_addr_a == ADDR_MAX);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DBG_WR_CLEAR;
      clr_ptr    <= '0;
      wr_ptr     <= '0;
      wr_count   <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      clearing   <= 1'b1;
      ram_en_a   <= 1'b0;
      ram_addr_a <= '0;
      ram_data_a <= '0;
    end else begin
      state      <= state_nxt;
      clr_ptr    <= clr_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      wr_count   <= wr_count_nxt;
      full       <= full_nxt;
      overflow   <= overflow_nxt;
      clearing   <= clearing_nxt;
      ram_en_a   <= ram_en_nxt;
      ram_addr_a <= ram_addr_nxt;
      ram_data_a <= ram_data_nxt;
    end
  end

  // Next-state, port mux and combinational ready
  always_comb begin
    state_nxt    = state;
    clr_ptr_nxt  = clr_ptr;
    wr_ptr_nxt   = wr_ptr;
    wr_count_nxt = wr_count;
    full_nxt     = full;
    overflow_nxt = overflow;
    ram_en_nxt   = 1'b0;
    ram_addr_nxt = ram_addr_a;
    ram_data_nxt = ram_data_a;
    in_ready     = 1'b0;

    case (state)
      DBG_WR_CLEAR: begin
        if (sweep_last_on_port) begin
          state_nxt    = DBG_WR_RUN;
          wr_ptr_nxt   = '0;
          wr_count_nxt = '0;
          full_nxt     = 1'b0;
          overflow_nxt = 1'b0;
        end else begin
          ram_en_nxt   = 1'b1;
          ram_addr_nxt = clr_ptr;
          ram_data_nxt = CLEAR_VAL;
          clr_ptr_nxt  = clr_ptr + ADDR_W'(1);
        end
      end

      DBG_WR_RUN: begin
        in_ready = ~clear_req;
        if (clear_req) begin
          state_nxt   = DBG_WR_CLEAR;
          clr_ptr_nxt = '0;
        end else if (in_valid) begin
          ram_en_nxt   = 1'b1;
          ram_addr_nxt = wr_ptr;
          ram_data_nxt = in_data;
          wr_ptr_nxt   = wr_ptr + ADDR_W'(1);
          if (wr_count != CNT_MAX) begin
            wr_count_nxt = wr_count + CNT_W'(1);
          end
`ifdef DEBUG_RAM_WR_WRAP_EN
          if (full) begin
            overflow_nxt = 1'b1;
          end
          if (wr_count == CNT_LAST) begin
            full_nxt = 1'b1;
          end
`else
          if (wr_count == CNT_LAST) begin
            full_nxt  = 1'b1;
            state_nxt = DBG_WR_FULL;
          end
`endif
        end
      end

      DBG_WR_FULL: begin
        if (in_valid) begin
          overflow_nxt = 1'b1;
        end
        if (clear_req) begin
          state_nxt   = DBG_WR_CLEAR;
          clr_ptr_nxt = '0;
        end
      end

      default: begin
        state_nxt   = DBG_WR_CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase

    clearing_nxt = (state_nxt == DBG_WR_CLEAR);
  end

endmodule : debug_ram_wr

// File: tb/tb_debug_ram_wr.sv
// Randomized bench for debug_ram_wr against a per-cycle behavioural model.
`timescale 1ns/1ps
module tb_debug_ram_wr;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1024;
  localparam logic [DW-1:0] CLR = 8'h00;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          clear_req;
  logic          ram_en_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_data_a;
  logic          clearing;
  logic          full;
  logic          overflow;
  logic [AW:0]   wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: clearing cycles left (incl. the tail cycle), bytes accepted since clear
  int            m_clr;
  int            m_acc;
  bit            m_ovf;
  bit            m_stop;
  bit            exp_en;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  debug_ram_wr #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_VAL(CLR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .clear_req  (clear_req),
    .ram_en_a   (ram_en_a),
    .ram_addr_a (ram_addr_a),
    .ram_data_a (ram_data_a),
    .clearing   (clearing),
    .full       (full),
    .overflow   (overflow),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_count();
    return (m_acc > int'(DEPTH)) ? int'(DEPTH) : m_acc;
  endfunction

  task automatic model_reset();
    m_clr  = int'(DEPTH) + 1;
    m_acc  = 0;
    m_ovf  = 1'b0;
    m_stop = 1'b0;
  endtask

  task automatic check_outputs();
    chk("ram_en_a", 32'(ram_en_a), 32'(exp_en));
    if (exp_en) begin
      chk("ram_addr_a", 32'(ram_addr_a), 32'(exp_addr));
      chk("ram_data_a", 32'(ram_data_a), 32'(exp_data));
    end
    chk("clearing", 32'(clearing), 32'(m_clr > 0));
    chk("full", 32'(full), 32'(m_acc >= int'(DEPTH)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("wr_count", 32'(wr_count), 32'(exp_count()));
  endtask

  // One clock: drive at a falling edge, predict, check after the next rising edge
  task automatic step(input bit v, input logic [DW-1:0] d, input bit c);
    bit rdy;
    in_valid  = v;
    in_data   = d;
    clear_req = c;
    #1;
    rdy = (m_clr == 0) && !m_stop && !c;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    exp_en = 1'b0;
    if (m_clr > 0) begin
      if (m_clr > 1) begin
        exp_en   = 1'b1;
        exp_addr = AW'(int'(DEPTH) + 1 - m_clr);
        exp_data = CLR;
      end
      m_clr--;
      if (m_clr == 0) begin
        m_acc  = 0;
        m_ovf  = 1'b0;
        m_stop = 1'b0;
      end
    end else begin
      if (m_stop && v) m_ovf = 1'b1;
      if (c) begin
        m_clr = int'(DEPTH) + 1;
      end else if (!m_stop && v) begin
        exp_en   = 1'b1;
        exp_addr = AW'(m_acc % int'(DEPTH));
        exp_data = d;
        if (m_acc >= int'(DEPTH)) m_ovf = 1'b1;
        m_acc++;
`ifndef DEBUG_RAM_WR_WRAP_EN
        if (m_acc == int'(DEPTH)) m_stop = 1'b1;
`endif
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_values();
    chk("rst_clearing", 32'(clearing), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ram_en_a", 32'(ram_en_a), 32'd0);
    chk("rst_ram_addr_a", 32'(ram_addr_a), 32'd0);
    chk("rst_ram_data_a", 32'(ram_data_a), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), 1'b0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_acc;
    int guard;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clear_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // Reset sweep: 1024 clear writes then ready
    idle(int'(DEPTH) + 1);
    idle(2);

    // Back-to-back stream 0x00..0x1F
    for (int i = 0; i < 32; i++) step(1'b1, DW'(i), 1'b0);
    // Eight more to reach write pointer 40
    for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), 1'b0);
    // Clear request with a byte offered the same cycle
    step(1'b1, 8'hA5, 1'b1);
    idle(int'(DEPTH) + 2);

    // Random valid pattern for 20 accepted bytes
    start_acc = m_acc;
    guard = 0;
    while ((m_acc - start_acc) < 20 && guard < 400) begin
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
      guard++;
    end
    chk("random_accepted", 32'(m_acc - start_acc), 32'd20);

    // Restart from empty, then offer 1030 bytes with an occasional gap
    step(1'b0, '0, 1'b1);
    idle(int'(DEPTH) + 1);
    for (int i = 0; i < 1030; i++) begin
      if ($urandom_range(0, 15) == 0) step(1'b0, DW'($urandom), 1'b0);
      step(1'b1, DW'(i), 1'b0);
    end
    idle(3);
    for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b0);

    // Clear from full together with a byte, then reset mid-sweep
    step(1'b1, 8'h5A, 1'b1);
    idle(100);
    rst_n = 1'b0;
    in_valid  = 1'b0;
    clear_req = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    idle(int'(DEPTH) + 1);
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_debug_ram_wr
